lfsr_period_monitor: RTL and testbench
======================================

// Module: lfsr_period_monitor
// PURPOSE
//  Downstream checker for the 4-bit LFSR output w. Samples the LFSR state stream, captures a
//  reference value and measures the sequence period: the number of samples until the reference
//  recurs. Flags the all-zero lock-up state and any early repeat (a cycle that excludes the
//  reference). Reports whether the period is maximal (2^WIDTH-1).
// PARAMETERS
//  WIDTH        4  LFSR state width; legal 2..8 (the seen-bitmap is 2^WIDTH bits)
//  ZERO_ILLEGAL 1  1: din==0 is an error (XOR LFSR lock-up); 0: zero is an ordinary value
// PORTS
//  clk      in   1          single clock, rising edge
//  rst      in   1          asynchronous, active-high reset
//  start    in   1          pulse: clear results and begin a new measurement
//  en       in   1          din valid this cycle; sample only when en=1
//  din      in   WIDTH      LFSR state (w) to be checked
//  busy     out  1          measurement in progress (CAPTURE or RUN)
//  done     out  1          result valid; held until next start
//  period   out  WIDTH+1    measured period; 0 when an error ended the run
//  maximal  out  1          done & (period == 2^WIDTH-1)
//  err_zero   out 1         run ended on din==0 (only when ZERO_ILLEGAL=1)
//  err_repeat out 1         run ended on repeat of a non-reference value
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=done=maximal=err_zero=err_repeat=0; period=0;
//   ref=0; count=0; seen bitmap all 0. Reset mid-run discards the run.
//  State registers: ref[WIDTH-1:0], count[WIDTH:0], seen[2^WIDTH-1:0], state.
//  IDLE: busy=0. start=1 -> CAPTURE; clear seen, count, period, done and error flags.
//  CAPTURE: busy=1. On en=1: if ZERO_ILLEGAL & din==0 -> err_zero=1, period=0, DONE.
//   Else ref<=din, seen[din]<=1, count<=0 -> RUN. en=0: hold.
//  RUN: busy=1. On en=1, priority order:
//   1. ZERO_ILLEGAL & din==0 -> err_zero=1, period=0 -> DONE
//   2. din==ref -> period<=count+1 -> DONE
//   3. seen[din]==1 -> err_repeat=1, period=0 -> DONE
//   4. else seen[din]<=1, count<=count+1, stay RUN
//   en=0: all registers hold; en gaps do not affect period.
//  DONE: busy=0, done=1; period/flags/maximal held until start or rst.
//  start in any state (incl. CAPTURE/RUN) aborts and restarts as from IDLE; start has priority
//   over en in the same cycle; din on the start cycle is NOT sampled (first capture is the
//   first en=1 cycle strictly after start).
//  Latency: done rises on the clock edge that samples the terminating din; outputs registered.
//  Width: count never exceeds 2^WIDTH-1 (pigeonhole: seen bitmap forces exit within 2^WIDTH
//   samples), so WIDTH+1 bits cannot overflow; no timeout needed.
//  Exactly one of {err_zero, err_repeat, period!=0} is true when done=1.
// TESTING
//  1. WIDTH=4, model x^4+x^3+1 from seed 1111, en=1 every cycle, start pulse -> done after 16
//     samples, period=15, maximal=1, no errors.
//  2. Same stream with en toggling 1/0 each cycle -> period=15, maximal=1; done 31 cycles later.
//  3. din sequence 5,9,5 -> period=2, maximal=0, errors 0.
//  4. din sequence 1,2,3,2 -> err_repeat=1 on 4th sample, period=0; din 3,0 -> err_zero=1.
//  5. Assert rst during RUN, then start with seq of test 1 -> all outputs 0 during reset,
//     fresh result period=15 (no stale seen bits).
//  6. start re-pulsed mid-RUN -> busy stays 1, done=0, period measured from new capture =15.

Source files
------------

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream and flags lock-up or early repeats.
// Results register on the edge that samples the terminating din; en=0 stalls sampling.
module lfsr_period_monitor #(
    parameter int WIDTH        = 4,
    parameter bit ZERO_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             maximal,
    output logic             err_zero,
    output logic             err_repeat
);

    localparam int             DEPTH = 1 << WIDTH;
    localparam logic [WIDTH:0] MAXP  = (WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   ref_val;
    logic [WIDTH:0]     count;
    logic [DEPTH-1:0]   seen;
    logic               din_zero;
    logic [WIDTH:0]     count_nxt;

    assign din_zero  = ZERO_ILLEGAL && (din == '0);
    assign count_nxt = count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            period     <= '0;
            maximal    <= 1'b0;
            err_zero   <= 1'b0;
            err_repeat <= 1'b0;
            ref_val    <= '0;
            count      <= '0;
            seen       <= '0;
        end else if (start) begin
            // Restart wins over en; din on this cycle is deliberately ignored.
            state      <= CAPTURE;
            busy       <= 1'b1;
            done       <= 1'b0;
            period     <= '0;
            maximal    <= 1'b0;
            err_zero   <= 1'b0;
            err_repeat <= 1'b0;
            count      <= '0;
            seen       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                CAPTURE: begin
                    if (en) begin
                        if (din_zero) begin
                            err_zero <= 1'b1;
                            period   <= '0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            ref_val   <= din;
                            seen[din] <= 1'b1;
                            count     <= '0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (din_zero) begin
                            err_zero <= 1'b1;
                            period   <= '0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else if (din == ref_val) begin
                            period  <= count_nxt;
                            maximal <= (count_nxt == MAXP);
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end else if (seen[din]) begin
                            // A cycle closed without passing through the reference.
                            err_repeat <= 1'b1;
                            period     <= '0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= DONE;
                        end else begin
                            seen[din] <= 1'b1;
                            count     <= count_nxt;
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Scoreboard bench: a queue-based sequence model predicts each result; a monitor checks on done.
module tb_lfsr_period_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       en;
    logic [3:0] din;
    logic       busy, done, maximal, err_zero, err_repeat;
    logic [4:0] period;

    lfsr_period_monitor #(.WIDTH(4), .ZERO_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .din(din),
        .busy(busy), .done(done), .period(period), .maximal(maximal),
        .err_zero(err_zero), .err_repeat(err_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     per;
        bit     maxi;
        bit     ez;
        bit     er;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    int     hist[$];
    bit     m_active = 1'b0;
    longint cyc = 0;
    int     npass = 0;
    int     ntot = 0;
    logic   done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: history of distinct values since capture; hist[0] is the reference.
    task automatic model_sample(input int d);
        exp_t e;
        bit   found;
        e.cyc = cyc;
        e.per = 0; e.maxi = 0; e.ez = 0; e.er = 0;
        if (d == 0) begin
            e.ez = 1;
            sb.push_back(e);
            m_active = 0;
        end else if (hist.size() == 0) begin
            hist.push_back(d);
        end else if (d == hist[0]) begin
            e.per  = hist.size();
            e.maxi = (hist.size() == 15);
            sb.push_back(e);
            m_active = 0;
        end else begin
            found = 0;
            foreach (hist[i]) if (hist[i] == d) found = 1;
            if (found) begin
                e.er = 1;
                sb.push_back(e);
                m_active = 0;
            end else begin
                hist.push_back(d);
            end
        end
    endtask

    task automatic step(input logic s, input logic e, input logic [3:0] d);
        start = s; en = e; din = d;
        @(posedge clk); #1;
        if (s) begin
            m_active = 1;
            hist.delete();
        end else if (e && m_active) begin
            model_sample(int'(d));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; en = 1'b0; din = 4'h0;
        m_active = 0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_period", period, 0);
        chk("rst_flags", {maximal, err_zero, err_repeat}, 0);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // mode 0: en always 1, mode 1: en toggles starting at 1, mode 2: random en
    task automatic feed_lfsr(input logic [3:0] seed, input int mode, input int max_samples);
        logic [3:0] s;
        logic       e;
        int         n;
        s = seed; n = 0;
        for (int i = 0; i < 200 && m_active && n < max_samples; i++) begin
            e = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            step(1'b0, e, s);
            if (e) begin
                s = lfsr_next(s);
                n++;
            end
        end
    endtask

    task automatic feed_list(input int vals[$]);
        foreach (vals[i]) step(1'b0, 1'b1, 4'(vals[i]));
    endtask

    task automatic settle();
        if (m_active && sb.size() == 0) chk("run_bound", 1, 0);
        repeat (2) step(1'b0, 1'b0, 4'h0);
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("period", period, x.per);
                chk("maximal", maximal, x.maxi);
                chk("err_zero", err_zero, x.ez);
                chk("err_repeat", err_repeat, x.er);
                chk("done_cycle", cyc, x.cyc);
                chk("busy_at_done", busy, 0);
            end
        end
        done_prev = done;
    end

    initial begin
        do_reset();

        // Full maximal-length run, en every cycle.
        step(1'b1, 1'b1, 4'h3);
        chk("busy_after_start", busy, 1);
        feed_lfsr(4'hF, 0, 100);
        settle();

        // Same stream with en toggling.
        step(1'b1, 1'b0, 4'h0);
        feed_lfsr(4'hF, 1, 100);
        settle();

        // Short period, repeat error, zero lock-up.
        step(1'b1, 1'b0, 4'h0);
        feed_list('{5, 9, 5});
        settle();
        step(1'b1, 1'b0, 4'h0);
        feed_list('{1, 2, 3, 2});
        settle();
        step(1'b1, 1'b0, 4'h0);
        feed_list('{3, 0});
        settle();
        step(1'b1, 1'b0, 4'h0);
        feed_list('{0});
        settle();

        // Reset in the middle of a run, then a clean run.
        step(1'b1, 1'b0, 4'h0);
        feed_lfsr(4'hF, 0, 5);
        do_reset();
        step(1'b1, 1'b0, 4'h0);
        feed_lfsr(4'hF, 0, 100);
        settle();

        // Restart mid-run; the start-cycle din must not be captured.
        step(1'b1, 1'b0, 4'h0);
        feed_lfsr(4'hF, 0, 6);
        step(1'b1, 1'b1, 4'h7);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        feed_lfsr(4'hF, 0, 100);
        settle();

        // Random streams and random-seed LFSR runs with random en.
        for (int t = 0; t < 40; t++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if (t % 3 == 0) begin
                feed_lfsr(4'($urandom_range(1, 15)), 2, 100);
            end else begin
                for (int i = 0; i < 200 && m_active; i++)
                    step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
            settle();
        end

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
